// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped timer: FSM states, register offsets,
// CTRL field positions and mode encodings.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [3:0] CTRL_OFF   = 4'h0;
  localparam logic [3:0] PRESET_OFF = 4'h4;
  localparam logic [3:0] COUNT_OFF  = 4'h8;

  localparam int EN_BIT   = 0;
  localparam int MODE_LSB = 1;
  localparam int IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped one-shot / auto-reload timer with level interrupt output.
// Auto-reload (MODE1) is compiled in only when TIMER_AUTORELOAD_EN is defined.
//
//   state | meaning
//   IDLE  | waiting for EN, irq_flag cleared on exit
//   LOAD  | COUNT <= PRESET
//   CNT   | decrementing COUNT, leaves on !EN or expiry
//   INT   | expiry: one-shot drops EN, auto-reload drops irq_flag
module timer_counter
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic [29:0] word_off;
  logic        in_win;
  logic [3:0]  byte_off;
  logic        wr_ok;
  logic        ctrl_wr;
  logic        preset_wr;
  logic        reload;
  logic        unused_addr_bits;

  // Word-granular offset from the base; the byte lane bits are ignored.
  assign word_off         = addr[31:2] - BASE_ADDR[31:2];
  assign in_win           = (word_off[29:2] == 28'd0);
  assign byte_off         = {word_off[1:0], 2'b00};
  assign unused_addr_bits = ^addr[1:0];

  assign wr_ok     = we && (byteen == 4'b1111) && in_win;
  assign ctrl_wr   = wr_ok && (byte_off == CTRL_OFF);
  assign preset_wr = wr_ok && (byte_off == PRESET_OFF);

`ifdef TIMER_AUTORELOAD_EN
  assign reload = (ctrl_q[MODE_LSB +: 2] == MODE_RELOAD);
`else
  assign reload = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_q[EN_BIT]) begin
          state_d    = ST_LOAD;
          irq_flag_d = 1'b0;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q[EN_BIT]) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // PRESET 0 lands here too, so it expires like PRESET 1 without wrapping.
          count_d    = 32'd0;
          irq_flag_d = 1'b1;
          state_d    = ST_INT;
        end
      end
      ST_INT: begin
        if (reload) begin
          irq_flag_d = 1'b0;
        end else begin
          ctrl_d[EN_BIT] = 1'b0;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (preset_wr) begin
      preset_d = wdata;
    end
    // A bus CTRL write overrides the FSM's EN clear and acknowledges the interrupt.
    if (ctrl_wr) begin
      ctrl_d     = wdata[3:0];
      irq_flag_d = 1'b0;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (in_win) begin
      case (byte_off)
        CTRL_OFF:   rdata = {28'd0, ctrl_q};
        PRESET_OFF: rdata = preset_q;
        COUNT_OFF:  rdata = count_q;
        default:    rdata = 32'd0;
      endcase
    end
  end

  assign irq = irq_flag_q & ctrl_q[IM_BIT];

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus randomized
// one-shot runs and register accesses checked against timing arithmetic.
`timescale 1ns/100ps
module tb_timer_counter;

  localparam logic [31:0] BASE     = 32'h0000_7F00;
  localparam logic [31:0] CTRL_A   = BASE;
  localparam logic [31:0] PRESET_A = BASE + 32'h4;
  localparam logic [31:0] COUNT_A  = BASE + 32'h8;

`ifdef TIMER_AUTORELOAD_EN
  localparam bit AUTORELOAD = 1'b1;
`else
  localparam bit AUTORELOAD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  byteen = 4'd0;
  logic [31:0] rdata;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  timer_counter #(.BASE_ADDR(BASE)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .we     (we),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    addr = a; wdata = d; byteen = be; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0; byteen = 4'd0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    #1 reset = 1'b0;
    #2;
    rd(CTRL_A, v);
    n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", v); end
    rd(PRESET_A, v);
    n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_preset: got %h want 0", v); end
    rd(COUNT_A, v);
    n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %h want 0", v); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    @(negedge clk) reset = 1'b1;

    wr(PRESET_A, 32'd10, 4'hF);
    wr(CTRL_A, 32'h9, 4'hF);
    v = 32'hFFFF_FFFF;
    for (int i = 0; i < 30 && v !== 32'd5; i++) begin
      tick;
      rd(COUNT_A, v);
    end
    n_tests++; if (v !== 32'd5) begin n_fail++; $display("FAIL reset_reach5: got %0d want 5", v); end
    reset = 1'b0;
    #1;
    rd(COUNT_A, v);
    n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL midreset_count: got %h want 0", v); end
    rd(CTRL_A, v);
    n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL midreset_ctrl: got %h want 0", v); end
    rd(PRESET_A, v);
    n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL midreset_preset: got %h want 0", v); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL midreset_irq: got %b want 0", irq); end
    @(negedge clk) reset = 1'b1;
    repeat (4) tick;
    rd(COUNT_A, v);
    n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL postreset_norestart: count %h want 0", v); end
  endtask

  // One-shot run: COUNT reads P..1 after E2.., irq = IM after E(Pe+2), EN drops after E(Pe+3).
  task automatic test_oneshot(input logic [31:0] p, input logic [3:0] c);
    logic [31:0] v;
    logic [31:0] pe;
    pe = (p == 32'd0) ? 32'd1 : p;
    wr(PRESET_A, p, 4'hF);
    wr(CTRL_A, {28'd0, c}, 4'hF);
    tick; tick;
    for (int k = 0; k < int'(pe); k++) begin
      rd(COUNT_A, v);
      n_tests++;
      if (v !== ((p == 32'd0) ? 32'd0 : p - 32'(k))) begin
        n_fail++; $display("FAIL oneshot_count p=%0d k=%0d: got %0d want %0d", p, k, v, p - 32'(k));
      end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_early_irq p=%0d k=%0d: got 1 want 0", p, k); end
      tick;
    end
    n_tests++; if (irq !== c[3]) begin n_fail++; $display("FAIL oneshot_irq p=%0d: got %b want %b", p, irq, c[3]); end
    rd(COUNT_A, v);
    n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL oneshot_count0 p=%0d: got %0d want 0", p, v); end
    tick;
    rd(CTRL_A, v);
    n_tests++; if (v !== {28'd0, c & 4'hE}) begin n_fail++; $display("FAIL oneshot_ctrl p=%0d: got %h want %h", p, v, c & 4'hE); end
    repeat (3) tick;
    n_tests++; if (irq !== c[3]) begin n_fail++; $display("FAIL oneshot_irq_held p=%0d: got %b want %b", p, irq, c[3]); end
    wr(CTRL_A, 32'd0, 4'hF);
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_ack p=%0d: got %b want 0", p, irq); end
  endtask

  task automatic test_autoreload;
    logic exp;
    wr(PRESET_A, 32'd2, 4'hF);
    wr(CTRL_A, 32'hB, 4'hF);
    for (int c = 1; c <= 25; c++) begin
      tick;
      exp = AUTORELOAD ? (c >= 4 && (c - 4) % 5 == 0) : (c >= 4);
      n_tests++; if (irq !== exp) begin n_fail++; $display("FAIL autoreload_irq cycle=%0d: got %b want %b", c, irq, exp); end
    end
    wr(CTRL_A, 32'd0, 4'hF);
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL autoreload_stop: got %b want 0", irq); end
    repeat (3) tick;
  endtask

  task automatic test_masked;
    logic [31:0] v;
    wr(PRESET_A, 32'd1, 4'hF);
    wr(CTRL_A, 32'h1, 4'hF);
    for (int c = 1; c <= 4; c++) begin
      tick;
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL masked_irq cycle=%0d: got %b want 0", c, irq); end
    end
    rd(CTRL_A, v);
    n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL masked_reached_int: ctrl %h want 0", v); end
    wr(CTRL_A, 32'h8, 4'hF);
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL masked_ack: got %b want 0", irq); end
    repeat (3) tick;
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL masked_ack_held: got %b want 0", irq); end
    wr(CTRL_A, 32'h0, 4'hF);
  endtask

  task automatic test_preset_during_count;
    logic [31:0] v;
    wr(PRESET_A, 32'd10, 4'hF);
    wr(CTRL_A, 32'h9, 4'hF);
    repeat (5) tick;
    rd(COUNT_A, v);
    n_tests++; if (v !== 32'd7) begin n_fail++; $display("FAIL pdc_count7: got %0d want 7", v); end
    wr(PRESET_A, 32'd100, 4'hF);
    rd(COUNT_A, v);
    n_tests++; if (v !== 32'd6) begin n_fail++; $display("FAIL pdc_count6: got %0d want 6", v); end
    tick;
    rd(COUNT_A, v);
    n_tests++; if (v !== 32'd5) begin n_fail++; $display("FAIL pdc_count5: got %0d want 5", v); end
    rd(PRESET_A, v);
    n_tests++; if (v !== 32'd100) begin n_fail++; $display("FAIL pdc_preset: got %0d want 100", v); end
    wr(CTRL_A, 32'h8, 4'hF);
    for (int c = 0; c < 5; c++) begin
      rd(COUNT_A, v);
      n_tests++; if (v !== 32'd4) begin n_fail++; $display("FAIL pdc_freeze c=%0d: got %0d want 4", c, v); end
      tick;
    end
    wr(CTRL_A, 32'h1, 4'hF);
    tick; tick;
    rd(COUNT_A, v);
    n_tests++; if (v !== 32'd100) begin n_fail++; $display("FAIL pdc_reload_new: got %0d want 100", v); end
    wr(CTRL_A, 32'h0, 4'hF);
    repeat (3) tick;
  endtask

  task automatic test_ignored_writes;
    logic [31:0] v, cnt0;
    wr(PRESET_A, 32'h1234_5678, 4'hF);
    rd(COUNT_A, cnt0);
    wr(PRESET_A, 32'hFFFF_FFFF, 4'b0011);
    rd(PRESET_A, v);
    n_tests++; if (v !== 32'h1234_5678) begin n_fail++; $display("FAIL ign_partial_be: preset %h want 12345678", v); end
    wr(COUNT_A, 32'hDEAD_BEEF, 4'hF);
    rd(COUNT_A, v);
    n_tests++; if (v !== cnt0) begin n_fail++; $display("FAIL ign_count_wr: count %h want %h", v, cnt0); end
    wr(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
    rd(BASE + 32'hC, v);
    n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL ign_off_c_read: got %h want 0", v); end
    rd(CTRL_A, v);
    n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL ign_off_c_ctrl: got %h want 0", v); end
    wr(CTRL_A, 32'hF, 4'b1110);
    rd(CTRL_A, v);
    n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL ign_ctrl_be: got %h want 0", v); end
    wr(BASE + 32'h14, 32'hAAAA_AAAA, 4'hF);
    wr(BASE - 32'h4, 32'h5555_5555, 4'hF);
    rd(PRESET_A, v);
    n_tests++; if (v !== 32'h1234_5678) begin n_fail++; $display("FAIL ign_outside: preset %h want 12345678", v); end
    rd(BASE + 32'h14, v);
    n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL ign_outside_read: got %h want 0", v); end
    wr(BASE + 32'h6, 32'h0000_CAFE, 4'hF);
    rd(PRESET_A, v);
    n_tests++; if (v !== 32'h0000_CAFE) begin n_fail++; $display("FAIL ign_lowbits: preset %h want 0000cafe", v); end
  endtask

  // Random accesses with EN kept low; the model is just the register contents.
  task automatic test_random_regs;
    logic [3:0]  ctrl_m;
    logic [31:0] preset_m, count_m, v, d, exp;
    logic [31:0] off;
    logic [3:0]  be;
    rd(CTRL_A, v);    ctrl_m = v[3:0];
    rd(PRESET_A, preset_m);
    rd(COUNT_A, count_m);
    for (int i = 0; i < 40; i++) begin
      off = 32'($urandom_range(0, 7)) * 32'd4;
      be  = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      d   = $urandom;
      if (off == 32'd0) d[0] = 1'b0;
      wr(BASE + off, d, be);
      if (be == 4'hF && off == 32'h0) ctrl_m = d[3:0];
      if (be == 4'hF && off == 32'h4) preset_m = d;
      case (off)
        32'h0:   exp = {28'd0, ctrl_m};
        32'h4:   exp = preset_m;
        32'h8:   exp = count_m;
        default: exp = 32'd0;
      endcase
      rd(BASE + off, v);
      n_tests++; if (v !== exp) begin n_fail++; $display("FAIL rand_read i=%0d off=%h: got %h want %h", i, off, v, exp); end
      rd(PRESET_A, v);
      n_tests++; if (v !== preset_m) begin n_fail++; $display("FAIL rand_preset i=%0d: got %h want %h", i, v, preset_m); end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rand_irq i=%0d: got %b want 0", i, irq); end
    end
    wr(CTRL_A, 32'd0, 4'hF);
  endtask

  task automatic test_back_to_back;
    logic [1:0] mode;
    logic [3:0] c;
    for (int i = 0; i < 6; i++) begin
      case ($urandom_range(0, 2))
        0:       mode = 2'd0;
        1:       mode = 2'd2;
        default: mode = 2'd3;
      endcase
      c = {1'($urandom_range(0, 1)), mode, 1'b1};
      test_oneshot(32'($urandom_range(0, 9)), c);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_oneshot(32'd3, 4'h9);
    test_oneshot(32'd0, 4'h9);
    test_autoreload;
    test_masked;
    test_preset_during_count;
    test_ignored_writes;
    test_random_regs;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped programmable timer that sits on the CPU's data-bus bridge, downstream of the pipeline's memory stage, and drives the CPU `interrupt` input. Software writes CTRL/PRESET through word stores, polls COUNT through loads, and receives an interrupt when the count expires. It runs in one-shot or auto-reload mode and is the standard device-side source for exception and interrupt tests.

## Interface
- `BASE_ADDR`, default 32'h0000_7F00, word-aligned base of the 3-register window (+0x0 CTRL, +0x4 PRESET, +0x8 COUNT).
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; clears all state immediately when low.
- `addr`  in  32  bus byte address; bits [1:0] ignored.
- `we`  in  1  bus write strobe, already qualified by the bridge's address decode.
- `byteen`  in  4  byte enables; a write takes effect only when `byteen == 4'b1111`.
- `wdata`  in  32  write data.
- `rdata`  out  32  combinational read data for `addr`.
- `irq`  out  1  interrupt request to the CPU, level.

## Operation
- CTRL[0] EN, CTRL[2:1] MODE (0 one-shot, 1 auto-reload, 2/3 treated as 0), CTRL[3] IM (irq mask). CTRL[31:4] read 0.
- PRESET: full 32-bit read/write. COUNT: read-only, writes ignored.
- Offsets other than 0x0/0x4/0x8 inside [BASE, BASE+0xF]: reads return 0, writes ignored. Addresses outside the window are ignored.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN -> LOAD, clear irq_flag.
  - LOAD: COUNT <= PRESET -> CNT.
  - CNT: if !EN -> IDLE, COUNT held. Else if COUNT > 1, COUNT-1. Else COUNT <= 0, irq_flag <= 1 -> INT.
  - INT, MODE0: EN <= 0 -> IDLE; irq_flag stays set.
  - INT, MODE1: irq_flag <= 0 -> IDLE, then reloads automatically.
- `irq = irq_flag & IM`.
- Any accepted CTRL write clears irq_flag. This is the software acknowledge.
- A PRESET write never disturbs the running COUNT; it takes effect at the next LOAD.
- COUNT arithmetic is unsigned 32-bit. PRESET 0 behaves as PRESET 1, with no underflow.

## Timing
- Reset values: CTRL 0, PRESET 0, COUNT 0, state IDLE, irq_flag 0. `irq` is 0 and `rdata` is 0 for every offset.
- Writes take effect at the edge where `we` is sampled. `rdata` reflects the register contents in the same cycle, with no read latency.
- The CTRL write edge that sets EN is E0. State is LOAD after E1, CNT with COUNT=PRESET after E2, and INT with `irq` high after E(PRESET+2).
- MODE1 period is PRESET+3 cycles between INT entries. `irq` is high for exactly one cycle per period.
- MODE0: `irq` stays high until a CTRL write or reset.
- If a bus CTRL write and an FSM EN-clear land on the same edge, the bus value wins and irq_flag is cleared. The FSM state transition still happens.
- Reset asserted mid-count: all state clears asynchronously. Counting restarts only after a fresh EN write.

## Configuration
- `TIMER_AUTORELOAD_EN` defined: MODE1 behaves as described above.
- Not defined: MODE1 is compiled out and every MODE value behaves as one-shot. CTRL[2:1] still read back as written.

## Structure
- Shared package `timer_pkg` holds:
  - the FSM state enum
  - offset constants CTRL_OFF/PRESET_OFF/COUNT_OFF
  - CTRL bit positions EN_BIT/MODE_LSB/IM_BIT
  - mode encodings
- A single module with no sub-module. The register file and the FSM share write-priority logic too tightly to split.

## Test plan
- Reset low mid-run with COUNT=5 -> COUNT, CTRL, `irq` all 0 immediately. Reads of all three offsets return 0.
- Write PRESET=3, then CTRL=0x9 (EN, IM, MODE0) at E0 -> COUNT reads 3, 2, 1 after E2, E3, E4. `irq`=1 after E5. CTRL reads 0x8 after E6. `irq` stays 1; a CTRL=0x0 write drops `irq` next cycle.
- PRESET=2, CTRL=0xB (MODE1) -> `irq` one-cycle pulses 5 cycles apart. Without `TIMER_AUTORELOAD_EN`, the same stimulus gives a single held `irq`.
- CTRL=0x1 (IM=0), PRESET=1 -> state reaches INT, `irq` stays 0. A later CTRL=0x8 write clears irq_flag, so `irq` stays 0.
- During CNT with COUNT=7: write PRESET=100 -> COUNT continues 6, 5… Write CTRL=0x8 -> COUNT freezes at its current value and state returns to IDLE.
- Write with byteen=4'b0011 to PRESET, and write to COUNT or offset 0xC -> no register changes.
